vproc_fpu_issue: RTL and testbench
==================================

# vproc_fpu_issue

Operand issue sequencer driving the vector FPU's `pipe_in` handshake. It accepts one vector instruction with full-register operands (vs1, vs2, vd and mask), then slices them into `FPU_OP_W`-wide beats. Each beat carries the per-beat control flags the FPU consumes: `first_cycle`, `last_cycle`, `vl_part`, `vl_part_0` and `last_vl_part`. The block sits between operand fetch and the FPU, and supports both element-parallel and 32-bit reduction issue.

## Interface
- `VREG_W`, default 128: vector register width in bits; a multiple of `FPU_OP_W`.
- `FPU_OP_W`, default 64: FPU datapath width in bits; a multiple of 32.
- `B` = `FPU_OP_W/8` (derived): bytes per beat.
- `NB` = `VREG_W/32` (derived): maximum beat count.

Ports:
- `clk_i`  in  1  clock.
- `async_rst_i`  in  1  reset, asynchronous and active-high.
- `instr_valid_i`  in  1  instruction offered.
- `instr_ready_o`  out  1  sequencer idle, can accept.
- `instr_vl_i`  in  `$clog2(VREG_W/8)+1`  number of valid bytes, 0..`VREG_W/8`.
- `instr_red_i`  in  1  reduction mode.
- `instr_op1_i`, `instr_op2_i`, `instr_op3_i`  in  `VREG_W`  vs1, vs2, vd.
- `instr_mask_i`  in  `VREG_W/8`  byte mask.
- `pipe_valid_o`  out  1  beat valid.
- `pipe_ready_i`  in  1  FPU accepts beat.
- `pipe_op1_o`, `pipe_op2_o`, `pipe_op3_o`  out  `FPU_OP_W`  beat operands.
- `pipe_mask_o`  out  `B`  beat byte mask.
- `pipe_first_cycle_o`  out  1  first beat of the instruction.
- `pipe_last_cycle_o`  out  1  last beat of the instruction.
- `pipe_vl_part_o`  out  `$clog2(B)`  index of the last valid byte in the beat.
- `pipe_vl_part_0_o`  out  1  beat has no valid bytes.

## Operation
The block has two states, IDLE and ISSUE.

- `instr_ready_o = (state==IDLE)`.
- **Accept.** On `instr_valid_i & instr_ready_o`:
  - Latch operands, mask, vl and red.
  - Clear beat counter `k`.
  - Compute beat count `N`:
    - Normal mode: `N = max(1, ceil(vl/B))`.
    - Reduction mode: `N = max(1, ceil(vl/4))`.
  - Go to ISSUE.
- **ISSUE.**
  - `pipe_valid_o = 1`.
  - On `pipe_valid_o & pipe_ready_i`:
    - If `k == N-1`, go to IDLE.
    - Otherwise `k <= k+1`.
- **Normal beat k.**
  - `pipe_opX_o = latched opX[k*FPU_OP_W +: FPU_OP_W]`.
  - `pipe_mask_o = mask[k*B +: B]`.
  - `rem = vl - k*B`.
  - `pipe_vl_part_o = min(rem,B) - 1`.
- **Reduction beat k.**
  - `pipe_op1_o = {0, op1[31:0]}` on every beat.
  - `pipe_op2_o = {0, op2[32k +: 32]}`.
  - `pipe_op3_o = 0`.
  - `pipe_mask_o = {0, mask[4k +: 4]}`.
  - `pipe_vl_part_o = min(vl - 4k, 4) - 1`.
- **Flags.**
  - `first_cycle = (k==0)`.
  - `last_cycle = (k==N-1)`.
  - `vl_part_0 = (vl==0)`: a single beat is issued with `first = last = 1`, `vl_part = 0`, operands still driven.
- `vl` is not a multiple of 4 in reduction mode: the partial last element is still issued; `vl_part` reflects the partial byte count.
- `instr_*` inputs are ignored while in ISSUE.

## Timing
- **Reset values:** state IDLE; `instr_ready_o = 1`; `pipe_valid_o = 0`; all pipe data and flag outputs 0; `k = 0`.
- **Latency:** instruction accepted at edge T → beat 0 valid in the cycle after T.
- **Throughput:** one beat per cycle while `pipe_ready_i = 1`.
- **Instruction occupancy:** N+1 cycles including a one-cycle IDLE bubble between instructions.
- **Output timing:** all `pipe_*` outputs are functions of registers only. There is no combinational path from `pipe_ready_i` or `instr_*` to any output.
- **Backpressure:** while `pipe_valid_o & ~pipe_ready_i`, every `pipe_*` output holds stable. Valid never drops before handshake.
- **Reset mid-ISSUE:**
  - Outputs return to reset values immediately (asynchronous).
  - The in-flight instruction is discarded.
  - After reset release the block is IDLE and accepts new instructions.
- **`instr_valid_i` high while in ISSUE:** not accepted (`ready = 0`). The upstream stage holds the instruction.

## Test plan
Parameters for all scenarios: `VREG_W = 128`, `FPU_OP_W = 64`.
- **Normal, vl=16, pipe_ready_i=1:** 2 beats.
  - Beat0: op2 = vs2[63:0], first=1, last=0, vl_part=7.
  - Beat1: op2 = vs2[127:64], first=0, last=1, vl_part=7.
  - `instr_ready_o` returns to 1 in the cycle after beat1 handshake.
- **Normal, vl=10:** 2 beats.
  - Beat0: vl_part=7.
  - Beat1: vl_part=1, mask = instr_mask[15:8].
- **vl=0:** exactly one beat with vl_part_0=1, first=1, last=1, vl_part=0.
- **Reduction, vl=12, vs1[31:0]=0x3F800000:** 3 beats.
  - op1 = 0x3F800000 on each beat.
  - op2 = vs2 elements 0, 1, 2, zero-extended.
  - vl_part = 3, 3, 3; last=1 only on beat2.
- **Backpressure:** `pipe_ready_i` held 0 for 3 cycles on beat0.
  - Outputs identical across those cycles; k does not advance.
  - Beat1 appears the cycle after `pipe_ready_i` rises.
  - A second instruction offered during ISSUE is not accepted until IDLE.
- **Reset mid-operation:** assert `async_rst_i` during beat0 of a vl=16 op.
  - `pipe_valid_o` falls asynchronously to 0.
  - After release, `instr_ready_o = 1`.
  - A new vl=8 instruction issues a single beat with first=last=1.

Source files
------------

// File: rtl/vproc_fpu_issue.sv
// Operand issue sequencer for the vector FPU: latches one full-register instruction
// and slices it into FPU_OP_W-wide beats (element-parallel or 32-bit reduction).
module vproc_fpu_issue #(
    parameter int unsigned VREG_W   = 128,
    parameter int unsigned FPU_OP_W = 64
) (
    input  logic                              clk_i,
    input  logic                              async_rst_i,

    input  logic                              instr_valid_i,
    output logic                              instr_ready_o,
    input  logic [$clog2(VREG_W/8):0]         instr_vl_i,
    input  logic                              instr_red_i,
    input  logic [VREG_W-1:0]                 instr_op1_i,
    input  logic [VREG_W-1:0]                 instr_op2_i,
    input  logic [VREG_W-1:0]                 instr_op3_i,
    input  logic [VREG_W/8-1:0]               instr_mask_i,

    output logic                              pipe_valid_o,
    input  logic                              pipe_ready_i,
    output logic [FPU_OP_W-1:0]               pipe_op1_o,
    output logic [FPU_OP_W-1:0]               pipe_op2_o,
    output logic [FPU_OP_W-1:0]               pipe_op3_o,
    output logic [FPU_OP_W/8-1:0]             pipe_mask_o,
    output logic                              pipe_first_cycle_o,
    output logic                              pipe_last_cycle_o,
    output logic [$clog2(FPU_OP_W/8)-1:0]     pipe_vl_part_o,
    output logic                              pipe_vl_part_0_o
);

    localparam int unsigned B   = FPU_OP_W / 8;
    localparam int unsigned NB  = VREG_W / 32;
    localparam int unsigned MW  = VREG_W / 8;
    localparam int unsigned VLW = $clog2(VREG_W/8) + 1;
    localparam int unsigned VPW = $clog2(B);
    localparam int unsigned KW  = $clog2(NB + 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [FPU_OP_W-1:0] op1;
        logic [FPU_OP_W-1:0] op2;
        logic [FPU_OP_W-1:0] op3;
        logic [B-1:0]        mask;
        logic                first;
        logic                last;
        logic [VPW-1:0]      vl_part;
        logic                vl_part_0;
    } beat_t;

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [KW-1:0]      n_q, n_d;
    logic [VREG_W-1:0]  op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [MW-1:0]      mask_q, mask_d;
    logic [VLW-1:0]     vl_q, vl_d;
    logic               red_q, red_d;
    beat_t              beat_q, beat_d;

    // Beat count: one beat per B bytes (normal) or per 32-bit element (reduction), at least one.
    function automatic logic [KW-1:0] beat_count(input logic [VLW-1:0] vl, input logic red);
        int per;
        int n;
        per = red ? 4 : int'(B);
        n   = (int'(vl) + per - 1) / per;
        if (n < 1) n = 1;
        return KW'(n);
    endfunction

    // Operands and control flags for beat k of a latched (or incoming) instruction.
    function automatic beat_t beat_calc(
        input logic [VREG_W-1:0] o1,
        input logic [VREG_W-1:0] o2,
        input logic [VREG_W-1:0] o3,
        input logic [MW-1:0]     m,
        input logic [VLW-1:0]    vl,
        input logic              red,
        input logic [KW-1:0]     k,
        input logic [KW-1:0]     n
    );
        beat_t b;
        int    per;
        int    rem;
        int    lim;
        b = '0;
        if (red) begin
            per    = 4;
            b.op1  = FPU_OP_W'(o1[31:0]);
            b.op2  = FPU_OP_W'(o2[int'(k)*32 +: 32]);
            b.mask = B'(m[int'(k)*4 +: 4]);
        end else begin
            per    = int'(B);
            b.op1  = o1[int'(k)*int'(FPU_OP_W) +: FPU_OP_W];
            b.op2  = o2[int'(k)*int'(FPU_OP_W) +: FPU_OP_W];
            b.op3  = o3[int'(k)*int'(FPU_OP_W) +: FPU_OP_W];
            b.mask = m[int'(k)*int'(B) +: B];
        end
        rem         = int'(vl) - int'(k) * per;
        lim         = (rem > per) ? per : rem;
        b.vl_part   = (vl == '0) ? '0 : VPW'(lim - 1);
        b.vl_part_0 = (vl == '0);
        b.first     = (k == '0);
        b.last      = (k == KW'(n - KW'(1)));
        return b;
    endfunction

    // Next-state, latch and beat-register logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        op3_d   = op3_q;
        mask_d  = mask_q;
        vl_d    = vl_q;
        red_d   = red_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    op1_d   = instr_op1_i;
                    op2_d   = instr_op2_i;
                    op3_d   = instr_op3_i;
                    mask_d  = instr_mask_i;
                    vl_d    = instr_vl_i;
                    red_d   = instr_red_i;
                    k_d     = '0;
                    n_d     = beat_count(instr_vl_i, instr_red_i);
                    beat_d  = beat_calc(instr_op1_i, instr_op2_i, instr_op3_i, instr_mask_i,
                                        instr_vl_i, instr_red_i, '0,
                                        beat_count(instr_vl_i, instr_red_i));
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (pipe_ready_i) begin
                    if (k_q == KW'(n_q - KW'(1))) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        k_d    = KW'(k_q + KW'(1));
                        beat_d = beat_calc(op1_q, op2_q, op3_q, mask_q, vl_q, red_q,
                                           KW'(k_q + KW'(1)), n_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            op3_q   <= '0;
            mask_q  <= '0;
            vl_q    <= '0;
            red_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            op3_q   <= op3_d;
            mask_q  <= mask_d;
            vl_q    <= vl_d;
            red_q   <= red_d;
            beat_q  <= beat_d;
        end
    end

    assign instr_ready_o      = (state_q == IDLE);
    assign pipe_valid_o       = (state_q == ISSUE);
    assign pipe_op1_o         = beat_q.op1;
    assign pipe_op2_o         = beat_q.op2;
    assign pipe_op3_o         = beat_q.op3;
    assign pipe_mask_o        = beat_q.mask;
    assign pipe_first_cycle_o = beat_q.first;
    assign pipe_last_cycle_o  = beat_q.last;
    assign pipe_vl_part_o     = beat_q.vl_part;
    assign pipe_vl_part_0_o   = beat_q.vl_part_0;

endmodule

// File: tb/tb_vproc_fpu_issue.sv
// Self-checking bench for vproc_fpu_issue: directed scenarios then random instructions
// with random backpressure, checked beat by beat against a byte-level reference model.
module tb_vproc_fpu_issue;

    logic         clk_i = 1'b0;
    logic         async_rst_i = 1'b1;
    logic         instr_valid_i = 1'b0;
    logic         instr_ready_o;
    logic [4:0]   instr_vl_i = '0;
    logic         instr_red_i = 1'b0;
    logic [127:0] instr_op1_i = '0;
    logic [127:0] instr_op2_i = '0;
    logic [127:0] instr_op3_i = '0;
    logic [15:0]  instr_mask_i = '0;
    logic         pipe_valid_o;
    logic         pipe_ready_i = 1'b0;
    logic [63:0]  pipe_op1_o;
    logic [63:0]  pipe_op2_o;
    logic [63:0]  pipe_op3_o;
    logic [7:0]   pipe_mask_o;
    logic         pipe_first_cycle_o;
    logic         pipe_last_cycle_o;
    logic [2:0]   pipe_vl_part_o;
    logic         pipe_vl_part_0_o;

    int nvec = 0;
    int nerr = 0;

    // Reference copy of the instruction currently in flight
    int           cur_vl;
    bit           cur_red;
    logic [127:0] cur_a, cur_b, cur_c;
    logic [15:0]  cur_m;

    vproc_fpu_issue #(.VREG_W(128), .FPU_OP_W(64)) dut (
        .clk_i              (clk_i),
        .async_rst_i        (async_rst_i),
        .instr_valid_i      (instr_valid_i),
        .instr_ready_o      (instr_ready_o),
        .instr_vl_i         (instr_vl_i),
        .instr_red_i        (instr_red_i),
        .instr_op1_i        (instr_op1_i),
        .instr_op2_i        (instr_op2_i),
        .instr_op3_i        (instr_op3_i),
        .instr_mask_i       (instr_mask_i),
        .pipe_valid_o       (pipe_valid_o),
        .pipe_ready_i       (pipe_ready_i),
        .pipe_op1_o         (pipe_op1_o),
        .pipe_op2_o         (pipe_op2_o),
        .pipe_op3_o         (pipe_op3_o),
        .pipe_mask_o        (pipe_mask_o),
        .pipe_first_cycle_o (pipe_first_cycle_o),
        .pipe_last_cycle_o  (pipe_last_cycle_o),
        .pipe_vl_part_o     (pipe_vl_part_o),
        .pipe_vl_part_0_o   (pipe_vl_part_0_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_beats();
        if (cur_vl == 0) return 1;
        return cur_red ? (cur_vl + 3) / 4 : (cur_vl + 7) / 8;
    endfunction

    // Expected beat k, derived directly from byte/element counts.
    task automatic exp_beat(input int k, output logic [63:0] e1, output logic [63:0] e2,
                            output logic [63:0] e3, output logic [7:0] em,
                            output logic [2:0] evp, output bit ef, output bit el, output bit ez);
        int width;
        int rem;
        if (cur_red) begin
            width = 4;
            e1 = {32'h0, cur_a[31:0]};
            e2 = 64'(cur_b >> (32 * k)) & 64'hFFFF_FFFF;
            e3 = 64'h0;
            em = 8'(cur_m >> (4 * k)) & 8'h0F;
        end else begin
            width = 8;
            e1 = 64'(cur_a >> (64 * k));
            e2 = 64'(cur_b >> (64 * k));
            e3 = 64'(cur_c >> (64 * k));
            em = 8'(cur_m >> (8 * k));
        end
        rem = cur_vl - k * width;
        evp = (cur_vl == 0) ? 3'd0 : 3'(((rem > width) ? width : rem) - 1);
        ef  = (k == 0);
        el  = (k == exp_beats() - 1);
        ez  = (cur_vl == 0);
    endtask

    task automatic check_beat(input int k);
        logic [63:0] e1, e2, e3;
        logic [7:0]  em;
        logic [2:0]  evp;
        bit          ef, el, ez;
        exp_beat(k, e1, e2, e3, em, evp, ef, el, ez);
        chk("valid", 128'(pipe_valid_o), 128'(1'b1));
        chk("busy_ready", 128'(instr_ready_o), 128'(1'b0));
        chk("op1", 128'(pipe_op1_o), 128'(e1));
        chk("op2", 128'(pipe_op2_o), 128'(e2));
        chk("op3", 128'(pipe_op3_o), 128'(e3));
        chk("mask", 128'(pipe_mask_o), 128'(em));
        chk("vl_part", 128'(pipe_vl_part_o), 128'(evp));
        chk("first", 128'(pipe_first_cycle_o), 128'(ef));
        chk("last", 128'(pipe_last_cycle_o), 128'(el));
        chk("vl_part_0", 128'(pipe_vl_part_0_o), 128'(ez));
    endtask

    // Offer one instruction from IDLE (called at posedge+1) and follow it to completion.
    task automatic run_instr(input int vl, input bit red, input logic [127:0] a,
                             input logic [127:0] b, input logic [127:0] c,
                             input logic [15:0] m, input int rdy_pct, input int hold0);
        int k;
        int cyc;
        int n;
        chk("idle_ready", 128'(instr_ready_o), 128'(1'b1));
        cur_vl = vl; cur_red = red; cur_a = a; cur_b = b; cur_c = c; cur_m = m;
        instr_vl_i = 5'(vl); instr_red_i = red;
        instr_op1_i = a; instr_op2_i = b; instr_op3_i = c; instr_mask_i = m;
        instr_valid_i = 1'b1;
        @(posedge clk_i); #1;
        // Keep offering garbage while busy: it must be ignored
        instr_valid_i = 1'($urandom_range(0, 1));
        instr_op1_i = {$urandom, $urandom, $urandom, $urandom};
        instr_op2_i = {$urandom, $urandom, $urandom, $urandom};
        instr_vl_i  = 5'($urandom_range(0, 16));
        instr_red_i = 1'($urandom_range(0, 1));
        n = exp_beats();
        k = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            check_beat(k);
            pipe_ready_i = (cyc < hold0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
            @(posedge clk_i); #1;
            if (pipe_ready_i) k++;
            cyc++;
        end
        if (cyc >= 200) begin
            nvec++;
            nerr++;
            $error("FAIL timeout observed=%0d beats expected=%0d", k, n);
        end
        instr_valid_i = 1'b0;
        pipe_ready_i = 1'b0;
        chk("done_valid", 128'(pipe_valid_o), 128'(1'b0));
        chk("done_ready", 128'(instr_ready_o), 128'(1'b1));
    endtask

    initial begin
        logic [127:0] a, b, c;
        // Reset values
        #3;
        chk("rst_valid", 128'(pipe_valid_o), 128'(1'b0));
        chk("rst_ready", 128'(instr_ready_o), 128'(1'b1));
        chk("rst_op1", 128'(pipe_op1_o), 128'(0));
        chk("rst_first", 128'(pipe_first_cycle_o), 128'(0));
        chk("rst_vl_part_0", 128'(pipe_vl_part_0_o), 128'(0));
        @(negedge clk_i); async_rst_i = 1'b0;
        @(posedge clk_i); #1;

        a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        b = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        c = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;

        run_instr(16, 1'b0, a, b, c, 16'hF0F0, 100, 0);
        run_instr(10, 1'b0, a, b, c, 16'h3CA5, 100, 0);
        run_instr(0,  1'b0, a, b, c, 16'hFFFF, 100, 0);
        run_instr(12, 1'b1, {a[127:32], 32'h3F80_0000}, b, c, 16'h0963, 100, 0);
        run_instr(7,  1'b1, a, b, c, 16'hFFFF, 100, 0);
        // Backpressure on beat0 for three cycles
        run_instr(16, 1'b0, b, c, a, 16'h1234, 100, 3);

        // Asynchronous reset during beat0
        cur_vl = 16; cur_red = 1'b0; cur_a = a; cur_b = b; cur_c = c; cur_m = 16'hFFFF;
        instr_vl_i = 5'd16; instr_red_i = 1'b0;
        instr_op1_i = a; instr_op2_i = b; instr_op3_i = c; instr_mask_i = 16'hFFFF;
        instr_valid_i = 1'b1;
        @(posedge clk_i); #1;
        instr_valid_i = 1'b0;
        check_beat(0);
        #2 async_rst_i = 1'b1;
        #1;
        chk("arst_valid", 128'(pipe_valid_o), 128'(1'b0));
        chk("arst_ready", 128'(instr_ready_o), 128'(1'b1));
        chk("arst_op2", 128'(pipe_op2_o), 128'(0));
        chk("arst_first", 128'(pipe_first_cycle_o), 128'(0));
        @(negedge clk_i); async_rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_instr(8, 1'b0, c, a, b, 16'h00FF, 100, 0);

        // Random instructions with random backpressure
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            c = {$urandom, $urandom, $urandom, $urandom};
            run_instr($urandom_range(0, 16), 1'($urandom_range(0, 1)), a, b, c,
                      16'($urandom), $urandom_range(30, 100), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
